// File: rtl/vga_capture_rx.sv
// ============================================================================
// Module      : vga_capture_rx
// Description : VGA receive front end. Registers the incoming sync and colour
//               pins and recovers line and frame timing from the sync falls.
//               It locks after one clean frame, then issues one frame-buffer
//               write per active pixel.
//               Optional feature: define VGA_RX_CRC_EN to add a per-frame
//               CRC-16-CCITT over the written pixels (frame_crc/crc_valid).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_capture_rx #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic        wr_en,
    output logic [8:0]  wr_row,
    output logic [9:0]  wr_col,
    output logic [11:0] wr_data,
    output logic        frame_start,
    output logic        locked,
`ifdef VGA_RX_CRC_EN
    output logic [15:0] frame_crc,
    output logic        crc_valid,
`endif
    output logic [7:0]  err_count
);

    localparam logic [9:0] c_H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_H_TOTAL = 10'(H_TOTAL);
    localparam logic [9:0] c_V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_H_START = 10'(H_START);
    localparam logic [9:0] c_H_END   = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] c_V_START = 10'(V_START);
    localparam logic [9:0] c_V_END   = 10'(V_START + V_ACTIVE);
    localparam logic [9:0] c_CNT_MAX = 10'h3FF;

    localparam logic [1:0] c_SEARCH  = 2'd0;
    localparam logic [1:0] c_MEASURE = 2'd1;
    localparam logic [1:0] c_LOCKED  = 2'd2;

    logic        r_hs1, r_vs1, r_hs2, r_vs2;
    logic [3:0]  r_red1, r_green1, r_blue1;
    logic [9:0]  r_hc, r_vc;
    logic [1:0]  r_state;

    logic        w_hfall, w_vfall;
    logic [9:0]  w_hc, w_vc;
    logic        w_line_err, w_frame_err, w_err;
    logic [1:0]  w_state_nxt;
    logic        w_active, w_wr, w_fs;
    logic [9:0]  w_row_full, w_col_full;
    logic [11:0] w_data;

    // Stage 1 pin sampling, plus a one-cycle history of the syncs for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
            r_hs2    <= 1'b1;
            r_vs2    <= 1'b1;
            r_red1   <= 4'd0;
            r_green1 <= 4'd0;
            r_blue1  <= 4'd0;
        end else begin
            r_hs1    <= h_sync;
            r_vs1    <= v_sync;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            r_red1   <= red;
            r_green1 <= green;
            r_blue1  <= blue;
        end
    end

    assign w_hfall = r_hs2 & ~r_hs1;
    assign w_vfall = r_vs2 & ~r_vs1;
    assign w_data  = {r_blue1, r_green1, r_red1};

    // Position of the current stage-1 sample, timing checks and next FSM state
    always_comb begin
        w_hc = w_hfall ? 10'd0 : ((r_hc == c_CNT_MAX) ? r_hc : r_hc + 10'd1);
        w_vc = r_vc;
        if (w_vfall) begin
            w_vc = 10'd0;
        end else if (w_hfall && (r_vc != c_CNT_MAX)) begin
            w_vc = r_vc + 10'd1;
        end

        w_line_err  = (w_hfall && (r_hc != c_H_LAST)) || (!w_hfall && (w_hc == c_H_TOTAL));
        w_frame_err = w_vfall && (r_vc != c_V_LAST);
        w_err       = w_line_err | w_frame_err;

        w_state_nxt = r_state;
        case (r_state)
            c_SEARCH:  if (w_vfall) w_state_nxt = c_MEASURE;
            c_MEASURE: begin
                if (w_err)        w_state_nxt = c_SEARCH;
                else if (w_vfall) w_state_nxt = c_LOCKED;
            end
            c_LOCKED:  if (w_err) w_state_nxt = c_SEARCH;
            default:   w_state_nxt = c_SEARCH;
        endcase

        w_active   = (w_hc >= c_H_START) && (w_hc < c_H_END) &&
                     (w_vc >= c_V_START) && (w_vc < c_V_END);
        // The drop out of LOCKED takes effect on the erroring sample itself
        w_wr       = (w_state_nxt == c_LOCKED) && w_active;
        w_fs       = (r_state == c_LOCKED) && w_vfall && !w_err;
        w_row_full = w_vc - c_V_START;
        w_col_full = w_hc - c_H_START;
    end

    // Counters, FSM state and error tally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hc      <= 10'd0;
            r_vc      <= 10'd0;
            r_state   <= c_SEARCH;
            err_count <= 8'd0;
        end else begin
            r_hc    <= w_hc;
            r_vc    <= w_vc;
            r_state <= w_state_nxt;
            if ((r_state == c_LOCKED) && w_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // Registered write port; address and data hold while no write is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en       <= 1'b0;
            wr_row      <= 9'd0;
            wr_col      <= 10'd0;
            wr_data     <= 12'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            wr_en       <= w_wr;
            frame_start <= w_fs;
            locked      <= (w_state_nxt == c_LOCKED);
            if (w_wr) begin
                wr_row  <= w_row_full[8:0];
                wr_col  <= w_col_full;
                wr_data <= w_data;
            end
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [15:0] r_crc;

    function automatic logic [15:0] f_crc_step(input logic [15:0] crc, input logic [11:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 11; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Running frame CRC; latched and restarted at each clean locked frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc     <= 16'hFFFF;
            frame_crc <= 16'd0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= w_fs;
            if (w_fs) begin
                frame_crc <= r_crc;
                r_crc     <= 16'hFFFF;
            end else if (w_wr) begin
                r_crc <= f_crc_step(r_crc, w_data);
            end else if (w_state_nxt != c_LOCKED) begin
                r_crc <= 16'hFFFF;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_capture_rx.sv
// ============================================================================
// Module      : tb_vga_capture_rx
// Description : Directed bench for vga_capture_rx using a reduced raster
//               (24x14 clocks) so that many frames fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_capture_rx;

    localparam int TH = 24;
    localparam int TV = 14;
    localparam int HS = 6;
    localparam int HA = 12;
    localparam int VS = 3;
    localparam int VA = 8;
    localparam int NPIX = HA * VA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        h_sync = 1'b1;
    logic        v_sync = 1'b1;
    logic [3:0]  red = 4'd0, green = 4'd0, blue = 4'd0;
    logic        wr_en, frame_start, locked;
    logic [8:0]  wr_row;
    logic [9:0]  wr_col;
    logic [11:0] wr_data;
    logic [7:0]  err_count;
`ifdef VGA_RX_CRC_EN
    logic [15:0] frame_crc;
    logic        crc_valid;
`endif

    vga_capture_rx #(
        .H_TOTAL(TH), .V_TOTAL(TV), .H_START(HS),
        .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync),
        .red(red), .green(green), .blue(blue),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .frame_start(frame_start), .locked(locked),
`ifdef VGA_RX_CRC_EN
        .frame_crc(frame_crc), .crc_valid(crc_valid),
`endif
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // pattern 0: solid F0A, 1: ramp col[3:0] on red, 2: all zero
    int cur_pat = 0;
    function automatic int exp_pix(input int pat, input int col);
        if (pat == 0) return 12'hF0A;
        if (pat == 1) return col % 16;
        return 0;
    endfunction

    function automatic logic [15:0] ref_crc(input int n, input logic [11:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 11; b >= 0; b--) begin
                if (c[15] != d[b]) c = (c << 1) ^ 16'h1021;
                else               c = c << 1;
            end
        end
        return c;
    endfunction

    // Output monitor: cumulative totals sampled on the falling edge
    int tot_wr = 0, tot_fs = 0, tot_cv = 0, bad_data = 0, bad_ord = 0;
    int first_cyc = 0, lock_fall_cyc = 0, last_row = 0, last_col = 0;
    int p_row = 0, p_col = 0;
    bit have_prev = 0, prev_lock = 0, ord_ok;
    always @(negedge clk) begin
        if (wr_en) begin
            tot_wr++;
            if (int'(wr_data) != exp_pix(cur_pat, int'(wr_col))) bad_data++;
            if (have_prev) begin
                ord_ok = (int'(wr_row) == p_row && int'(wr_col) == p_col + 1) ||
                         (wr_col == 10'd0 && (int'(wr_row) == p_row + 1 || wr_row == 9'd0));
                if (!ord_ok) bad_ord++;
            end
            have_prev = 1;
            p_row = int'(wr_row);
            p_col = int'(wr_col);
            last_row = p_row;
            last_col = p_col;
            if (wr_row == 9'd0 && wr_col == 10'd0) first_cyc = cyc;
        end
        if (frame_start) tot_fs++;
`ifdef VGA_RX_CRC_EN
        if (crc_valid) tot_cv++;
`endif
        if (prev_lock && !locked) lock_fall_cyc = cyc;
        prev_lock = locked;
    end

    int t_first_pin = 0, t_err_pin = 0;

    task automatic check_all_zero(input string tag);
        check({tag, " wr_en"}, int'(wr_en), 0);
        check({tag, " locked"}, int'(locked), 0);
        check({tag, " frame_start"}, int'(frame_start), 0);
        check({tag, " err_count"}, int'(err_count), 0);
        check({tag, " wr_row"}, int'(wr_row), 0);
        check({tag, " wr_col"}, int'(wr_col), 0);
        check({tag, " wr_data"}, int'(wr_data), 0);
    endtask

    // Transmitter model: one frame, optional short line and mid-frame reset
    task automatic send_frame(input int nlines, input int short_line, input int pat, input int rst_line);
        int len;
        int col;
        cur_pat = pat;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_line) ? TH - 1 : TH;
            for (int c = 0; c < len; c++) begin
                @(posedge clk);
                #1;
                rst    = 1'b0;
                h_sync = (c < 3) ? 1'b0 : 1'b1;
                v_sync = (l < 2) ? 1'b0 : 1'b1;
                col    = c - HS;
                red = 4'd0; green = 4'd0; blue = 4'd0;
                if (l >= VS && l < VS + VA && c >= HS && c < HS + HA) begin
                    if (pat == 0) begin
                        blue = 4'hF; green = 4'h0; red = 4'hA;
                    end else if (pat == 1) begin
                        red = 4'(col % 16);
                    end
                end
                if (l == VS && c == HS) t_first_pin = cyc;
                if (l == short_line + 1 && c == 0) t_err_pin = cyc;
                if (l == rst_line && c == 10) begin
                    rst = 1'b1;
                    #1;
                    check_all_zero("async_rst");
                end
            end
        end
    endtask

    task automatic run_frame(input string nm, input int nlines, input int short_line, input int pat,
                             input int rst_line, input int e_wr, input int e_fs, input int e_lock,
                             input int e_err);
        int w0, f0;
        w0 = tot_wr;
        f0 = tot_fs;
        send_frame(nlines, short_line, pat, rst_line);
        check({nm, " writes"}, tot_wr - w0, e_wr);
        check({nm, " frame_start"}, tot_fs - f0, e_fs);
        check({nm, " locked"}, int'(locked), e_lock);
        check({nm, " err_count"}, int'(err_count), e_err);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Solid colour: lock at the second v fall, full frames afterwards
        run_frame("F1", TV, -5, 0, -1, 0, 0, 0, 0);
        run_frame("F2", TV, -5, 0, -1, NPIX, 0, 1, 0);
        run_frame("F3", TV, -5, 0, -1, NPIX, 1, 1, 0);

        // Ramp: address range, data and pin-to-write latency
        run_frame("F4", TV, -5, 1, -1, NPIX, 1, 1, 0);
        check("ramp last_row", last_row, VA - 1);
        check("ramp last_col", last_col, HA - 1);
        check("ramp latency", first_cyc - t_first_pin, 2);

        // Short line inside active area: drop, count, relock two v falls later
        run_frame("F5", TV, 5, 1, -1, 3 * HA, 1, 0, 1);
        check("short lock_drop_latency", lock_fall_cyc - t_err_pin, 2);
        run_frame("F6", TV, -5, 0, -1, 0, 0, 0, 1);
        run_frame("F7", TV, -5, 0, -1, NPIX, 0, 1, 1);

        // Short frame: error at the following v fall, no frame_start for it
        run_frame("F8", TV - 1, -5, 0, -1, NPIX, 1, 1, 1);
        run_frame("F9", TV, -5, 0, -1, 0, 0, 0, 2);
        run_frame("F10", TV, -5, 0, -1, 0, 0, 0, 2);
        run_frame("F11", TV, -5, 0, -1, NPIX, 0, 1, 2);

        // Asynchronous reset on line 5, then a full relock sequence
        run_frame("F12", TV, -5, 0, 5, 2 * HA + 2, 1, 0, 0);
        run_frame("F13", TV, -5, 2, -1, 0, 0, 0, 0);
        run_frame("F14", TV, -5, 2, -1, NPIX, 0, 1, 0);
        run_frame("F15", TV, -5, 2, -1, NPIX, 1, 1, 0);
`ifdef VGA_RX_CRC_EN
        check("crc_valid count", tot_cv, tot_fs);
        check("frame_crc zero", int'(frame_crc), int'(ref_crc(NPIX, 12'h000)));
`endif

        check("pixel data errors", bad_data, 0);
        check("address order errors", bad_ord, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
